color_manager_pattern_gen: RTL and testbench

- Downstream consumer of the colour-manager pixel counter stage.
- Takes that stage's per-line valid window (Counter_Valid) and active-pixel count (CounterP) and produces registered RGB pixel data.
- Supports four test patterns: colour bars, solid colour, checkerboard and horizontal ramp.
- Output feeds the colour output/serialiser path with a fixed 2-cycle latency.

---
 rtl/color_manager_pattern_gen.sv | 127 ++++++++++++
 tb/tb_color_manager_pattern_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/color_manager_pattern_gen.sv
// Test-pattern generator fed by the colour-manager pixel counter: turns the per-line
// valid window and pixel count into registered RGB (bars, solid, checker, ramp), 2-cycle latency.
module color_manager_pattern_gen #(
  parameter int FRONTPORCH_WIDTH = 11,
  parameter int COLOR_WIDTH      = 8,
  parameter int LINE_SHIFT       = 3
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          Counter_Valid,
  input  logic [FRONTPORCH_WIDTH-1:0]   CounterP,
  input  logic                          Frame_Start,
  input  logic [1:0]                    Mode,
  input  logic [FRONTPORCH_WIDTH-1:0]   Bar_Width,
  input  logic [3*COLOR_WIDTH-1:0]      Solid_Color,
  output logic [COLOR_WIDTH-1:0]        Red,
  output logic [COLOR_WIDTH-1:0]        Green,
  output logic [COLOR_WIDTH-1:0]        Blue,
  output logic                          Color_Valid
);

  localparam int FW = FRONTPORCH_WIDTH;
  localparam int CW = COLOR_WIDTH;

  logic                 cv_d;
  logic                 rise;
  logic                 fall;
  logic [1:0]           sh_mode;
  logic [FW-1:0]        sh_width;
  logic [3*CW-1:0]      sh_color;
  logic [FW-1:0]        eff_width_m1;
  logic [FW-1:0]        sub_cnt;
  logic [2:0]           bar_idx;
  logic [FW-1:0]        cp_r;
  logic                 v1;
  logic [LINE_SHIFT:0]  line_cnt;
  logic [CW-1:0]        nxt_r;
  logic [CW-1:0]        nxt_g;
  logic [CW-1:0]        nxt_b;

  assign rise         = Counter_Valid & ~cv_d;
  assign fall         = ~Counter_Valid & cv_d;
  assign eff_width_m1 = (sh_width == '0) ? '0 : sh_width - 1'b1;

  // Edge history follows the input even in reset, so a line already running when
  // reset releases is not mistaken for a new line start.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cv_d     <= Counter_Valid;
      sh_mode  <= '0;
      sh_width <= '0;
      sh_color <= '0;
      line_cnt <= '0;
      sub_cnt  <= '0;
      bar_idx  <= '0;
      cp_r     <= '0;
      v1       <= 1'b0;
    end else begin
      cv_d <= Counter_Valid;
      v1   <= Counter_Valid;
      cp_r <= CounterP;
      if (rise) begin
        sh_mode  <= Mode;
        sh_width <= Bar_Width;
        sh_color <= Solid_Color;
      end
      if (Frame_Start) begin
        line_cnt <= '0;
      end else if (fall) begin
        line_cnt <= line_cnt + 1'b1;
      end
      if (Counter_Valid) begin
        if (rise) begin
          sub_cnt <= '0;
          bar_idx <= '0;
        end else if (sub_cnt == eff_width_m1) begin
          sub_cnt <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          sub_cnt <= sub_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    nxt_r = '0;
    nxt_g = '0;
    nxt_b = '0;
    if (v1) begin
      case (sh_mode)
        2'd0: begin
          // Bit mapping yields white, yellow, cyan, green, magenta, red, blue, black.
          nxt_r = {CW{~bar_idx[1]}};
          nxt_g = {CW{~bar_idx[2]}};
          nxt_b = {CW{~bar_idx[0]}};
        end
        2'd1: {nxt_r, nxt_g, nxt_b} = sh_color;
        2'd2: begin
          if (bar_idx[0] ^ line_cnt[LINE_SHIFT]) begin
            {nxt_r, nxt_g, nxt_b} = sh_color;
          end
        end
        default: begin
          nxt_r = cp_r[CW-1:0];
          nxt_g = cp_r[CW-1:0];
          nxt_b = cp_r[CW-1:0];
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Red         <= '0;
      Green       <= '0;
      Blue        <= '0;
      Color_Valid <= 1'b0;
    end else begin
      Red         <= nxt_r;
      Green       <= nxt_g;
      Blue        <= nxt_b;
      Color_Valid <= v1;
    end
  end

endmodule

// File: tb/tb_color_manager_pattern_gen.sv
// Bench for color_manager_pattern_gen: cycle driver plus a pixel-position reference model
// whose per-cycle expectations sit in a 2-deep queue matching the pipeline latency.
module tb_color_manager_pattern_gen;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Counter_Valid = 1'b0;
  logic [10:0] CounterP = '0;
  logic        Frame_Start = 1'b0;
  logic [1:0]  Mode = '0;
  logic [10:0] Bar_Width = '0;
  logic [23:0] Solid_Color = '0;
  logic [7:0]  Red, Green, Blue;
  logic        Color_Valid;

  int errors = 0;
  int checks = 0;

  logic [24:0] exp_q[$];

  // Reference state: line geometry seen from the pixel stream.
  logic [1:0]  m_mode = '0;
  int          m_w = 0;
  logic [23:0] m_color = '0;
  int          m_k = 0;
  int          m_line = 0;
  bit          m_prev = 0;

  logic [23:0] bar_colors [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  color_manager_pattern_gen dut (
    .Clk(Clk), .Rst_n(Rst_n), .Counter_Valid(Counter_Valid), .CounterP(CounterP),
    .Frame_Start(Frame_Start), .Mode(Mode), .Bar_Width(Bar_Width), .Solid_Color(Solid_Color),
    .Red(Red), .Green(Green), .Blue(Blue), .Color_Valid(Color_Valid)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] model_rgb(input int cp);
    int b;
    b = (m_k / ((m_w == 0) ? 1 : m_w)) % 8;
    case (m_mode)
      2'd0:    return bar_colors[b];
      2'd1:    return m_color;
      2'd2:    return (((b % 2) ^ ((m_line / 8) % 2)) != 0) ? m_color : 24'h0;
      default: return {3{cp[7:0]}};
    endcase
  endfunction

  // One clock: sample the output due now, then drive this cycle's inputs and predict.
  task automatic cyc(input bit rst_v, input bit cv, input int cp, input bit fs,
                     output bit have, output logic [24:0] obs, output logic [24:0] exp_v);
    @(negedge Clk);
    have = 0;
    obs = '0;
    exp_v = '0;
    if (exp_q.size() == 2) begin
      have = 1;
      obs = {Color_Valid, Red, Green, Blue};
      exp_v = exp_q.pop_front();
    end
    Rst_n = rst_v;
    Counter_Valid = cv;
    CounterP = cp[10:0];
    Frame_Start = fs;
    if (!rst_v) begin
      if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
      exp_q.push_back('0);
      m_mode = '0; m_w = 0; m_color = '0; m_k = 0; m_line = 0; m_prev = cv;
    end else begin
      if (cv && !m_prev) begin
        m_mode = Mode; m_w = int'(Bar_Width); m_color = Solid_Color;
      end
      if (fs) m_line = 0;
      else if (!cv && m_prev) m_line = (m_line + 1) % 16;
      if (cv) m_k = (!m_prev) ? 0 : m_k + 1;
      exp_q.push_back(cv ? {1'b1, model_rgb(cp)} : 25'h0);
      m_prev = cv;
    end
  endtask

  task automatic test_reset();
    bit h; logic [24:0] o, e;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, i + 1, 0, h, o, e);
      if (h) begin
        checks++;
        if (o !== e) begin errors++; $display("FAIL reset_hold: got %h want %h", o, e); end
      end
    end
    for (int i = 0; i < 9; i++) begin
      cyc(1, (i < 6), (i < 6) ? i + 5 : 0, 0, h, o, e);
      if (h) begin
        checks++;
        if (o !== e) begin errors++; $display("FAIL reset_release: got %h want %h", o, e); end
      end
    end
  endtask

  task automatic test_bars();
    bit h; logic [24:0] o, e;
    Mode = 2'd0; Bar_Width = 11'd4; Solid_Color = 24'($urandom);
    for (int p = 1; p <= 43; p++) begin
      cyc(1, (p <= 40), (p <= 40) ? p : 0, 0, h, o, e);
      if (h) begin
        checks++;
        if (o !== e) begin errors++; $display("FAIL bars_w4 p%0d: got %h want %h", p, o, e); end
      end
    end
  endtask

  task automatic test_width0();
    bit h; logic [24:0] o, e;
    Mode = 2'd0; Bar_Width = 11'd0;
    for (int p = 1; p <= 22; p++) begin
      if (p == 6) Bar_Width = 11'd2;
      cyc(1, (p <= 20), (p <= 20) ? p : 0, 0, h, o, e);
      if (h) begin
        checks++;
        if (o !== e) begin errors++; $display("FAIL bars_w0 p%0d: got %h want %h", p, o, e); end
      end
    end
    for (int p = 1; p <= 19; p++) begin
      cyc(1, (p <= 16), (p <= 16) ? p : 0, 0, h, o, e);
      if (h) begin
        checks++;
        if (o !== e) begin errors++; $display("FAIL bars_w2 p%0d: got %h want %h", p, o, e); end
      end
    end
  endtask

  task automatic test_ramp();
    bit h; logic [24:0] o, e;
    Mode = 2'd3; Bar_Width = 11'($urandom_range(0, 7));
    for (int p = 1; p <= 303; p++) begin
      cyc(1, (p <= 300), (p <= 300) ? p : 0, 0, h, o, e);
      if (h) begin
        checks++;
        if (o !== e) begin errors++; $display("FAIL ramp p%0d: got %h want %h", p, o, e); end
      end
    end
  endtask

  task automatic test_checker();
    bit h; logic [24:0] o, e;
    Mode = 2'd2; Bar_Width = 11'd2; Solid_Color = 24'h123456;
    cyc(1, 0, 0, 1, h, o, e);
    for (int ln = 0; ln < 16; ln++) begin
      for (int p = 1; p <= 10; p++) begin
        cyc(1, (p <= 8), (p <= 8) ? p : 0, (ln == 3 && p == 9), h, o, e);
        if (h) begin
          checks++;
          if (o !== e) begin errors++; $display("FAIL checker l%0d p%0d: got %h want %h", ln, p, o, e); end
        end
      end
    end
  endtask

  task automatic test_midline_reset();
    bit h; logic [24:0] o, e;
    Mode = 2'd1; Bar_Width = 11'd3; Solid_Color = 24'($urandom);
    for (int p = 1; p <= 23; p++) begin
      cyc((p != 10), (p <= 20), (p <= 20) ? p : 0, 0, h, o, e);
      if (h) begin
        checks++;
        if (o !== e) begin errors++; $display("FAIL midline_reset p%0d: got %h want %h", p, o, e); end
      end
    end
    for (int p = 1; p <= 11; p++) begin
      cyc(1, (p <= 8), (p <= 8) ? p : 0, 0, h, o, e);
      if (h) begin
        checks++;
        if (o !== e) begin errors++; $display("FAIL after_reset_line p%0d: got %h want %h", p, o, e); end
      end
    end
  endtask

  task automatic test_random();
    bit h; logic [24:0] o, e;
    int len, gap;
    for (int ln = 0; ln < 12; ln++) begin
      Mode = 2'($urandom_range(0, 3));
      Bar_Width = 11'($urandom_range(0, 5));
      Solid_Color = 24'($urandom);
      len = (ln == 0) ? 1 : int'($urandom_range(1, 40));
      gap = int'($urandom_range(1, 4));
      for (int p = 1; p <= len + gap; p++) begin
        if (p == 3) begin
          Mode = 2'($urandom_range(0, 3));
          Bar_Width = 11'($urandom_range(0, 5));
          Solid_Color = 24'($urandom);
        end
        cyc(1, (p <= len), (p <= len) ? p : 0,
            (p > len) && ($urandom_range(0, 3) == 0), h, o, e);
        if (h) begin
          checks++;
          if (o !== e) begin errors++; $display("FAIL random l%0d p%0d: got %h want %h", ln, p, o, e); end
        end
      end
    end
    for (int p = 0; p < 3; p++) begin
      cyc(1, 0, 0, 0, h, o, e);
      if (h) begin
        checks++;
        if (o !== e) begin errors++; $display("FAIL random_drain: got %h want %h", o, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_width0();
    test_ramp();
    test_checker();
    test_midline_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
